// File: rtl/axis_frame_generator.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_generator
// Brief    : AXI4-Stream frame source. Emits frameCount frames (0 = until
//            abort) of frameLen+1 counter-pattern beats each, with last on
//            the final beat and a programmable idle gap between frames.
//            Fully honours sink backpressure; abort ends a run only at a
//            frame boundary or during an inter-frame gap.
// Options  : FRAME_GEN_SEED_ADVANCE_EN - when defined, each frame continues
//            the data counter from the previous frame's last value + 1;
//            when undefined, every frame restarts at the latched seed.
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_generator #(
    parameter int DATA_WIDTH = 3,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_WIDTH-1:0]  frameLen,
    input  logic [7:0]            frameCount,
    input  logic [3:0]            gap,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            framesSent,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam logic [DATA_WIDTH-1:0] c_data_one = DATA_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  c_len_one  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  c_len_zero = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [7:0]            r_count;
    logic [3:0]            r_gap;
    logic [3:0]            r_gap_cnt;
    logic [LEN_WIDTH-1:0]  r_beat;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_done;
    logic [7:0]            r_sent;

    logic                  w_accept;
    logic                  w_xfer;
    logic [7:0]            w_sent_next;
    logic                  w_run_over;
    logic [DATA_WIDTH-1:0] w_data_inc;
    logic [LEN_WIDTH-1:0]  w_beat_inc;
    logic [DATA_WIDTH-1:0] w_next_start;

    // abort beats start when both are seen together in IDLE
    assign w_accept    = (r_state == ST_IDLE) && start && !abort;
    assign w_xfer      = r_valid && out_ready;
    assign w_sent_next = r_sent + 8'd1;
    // run ends on reaching a non-zero frame budget, or on a pending abort
    assign w_run_over  = ((r_count != 8'd0) && (w_sent_next == r_count)) || abort;
    assign w_data_inc  = r_data + c_data_one;
    assign w_beat_inc  = r_beat + c_len_one;

`ifdef FRAME_GEN_SEED_ADVANCE_EN
    // next frame simply carries on the running counter
    assign w_next_start = w_data_inc;
`else
    logic [DATA_WIDTH-1:0] r_seed;

    // hold the run's seed so every frame can restart from it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_seed <= '0;
        end else if (w_accept) begin
            r_seed <= seed;
        end
    end

    assign w_next_start = r_seed;
`endif

    // frame sequencer: IDLE -> SEND <-> GAP, all outputs registered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_count   <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_beat    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sent    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_len   <= frameLen;
                        r_count <= frameCount;
                        r_gap   <= gap;
                        r_sent  <= '0;
                        r_beat  <= '0;
                        r_data  <= seed;
                        r_last  <= (frameLen == c_len_zero);
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // nothing moves while stalled, so data/last stay stable
                    if (w_xfer) begin
                        if (r_last) begin
                            r_sent <= w_sent_next;
                            r_beat <= '0;
                            r_data <= w_next_start;
                            if (w_run_over) begin
                                r_state <= ST_IDLE;
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else if (r_gap == 4'd0) begin
                                r_last <= (r_len == c_len_zero);
                            end else begin
                                // gap counter is preloaded so valid is low exactly r_gap cycles
                                r_state   <= ST_GAP;
                                r_valid   <= 1'b0;
                                r_last    <= 1'b0;
                                r_gap_cnt <= r_gap - 4'd1;
                            end
                        end else begin
                            r_beat <= w_beat_inc;
                            r_data <= w_data_inc;
                            r_last <= (w_beat_inc == r_len);
                        end
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_gap_cnt == 4'd0) begin
                        r_state <= ST_SEND;
                        r_valid <= 1'b1;
                        r_last  <= (r_len == c_len_zero);
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign framesSent = r_sent;
    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign out_last   = r_last;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_frame_generator
// Brief    : Self-checking bench for axis_frame_generator. A frame-level
//            reference model predicts every beat, gap and end-of-run pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_frame_generator;

    localparam int DW = 3;
    localparam int LW = 8;

    logic          clk;
    logic          resetn;
    logic          start;
    logic          abort;
    logic [LW-1:0] frameLen;
    logic [7:0]    frameCount;
    logic [3:0]    gap;
    logic [DW-1:0] seed;
    logic          busy;
    logic          done;
    logic [7:0]    framesSent;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;

    int            n_vec;
    int            n_err;
    logic [0:6]    rdy_pat;

    axis_frame_generator #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .frameLen   (frameLen),
        .frameCount (frameCount),
        .gap        (gap),
        .seed       (seed),
        .busy       (busy),
        .done       (done),
        .framesSent (framesSent),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete run. rmode: 0 ready high, 1 random ready, 2 directed pattern.
    // amode: 0 none, 1 raise abort on beat 1 of frame index aframe,
    //        2 raise abort in the gap that follows frame index aframe.
    task automatic do_run(input int len, input int cnt, input int gp, input int sd,
                          input int rmode, input int amode, input int aframe);
        int beat, frame, sent, gap_left, start_f;
        bit expv, fin, rdy;
        frameLen   = LW'(len);
        frameCount = 8'(cnt);
        gap        = 4'(gp);
        seed       = DW'(sd);
        abort      = 1'b0;
        out_ready  = 1'b0;
        start      = 1'b1;
        tick();
        start    = 1'b0;
        beat     = 0;
        frame    = 0;
        sent     = 0;
        gap_left = 0;
        expv     = 1'b1;
        fin      = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            chk("valid", out_valid, expv);
            chk("busy", busy, 1'b1);
            chk("done_low", done, 1'b0);
            chk("framesSent", framesSent, 8'(sent));
            if (expv) begin
`ifdef FRAME_GEN_SEED_ADVANCE_EN
                start_f = sd + frame * (len + 1);
`else
                start_f = sd;
`endif
                chk("data", out_data, (start_f + beat) % (1 << DW));
                chk("last", out_last, beat == len);
            end
            // configuration changes during a run must be ignored
            frameLen   = LW'($urandom);
            frameCount = 8'($urandom);
            gap        = 4'($urandom);
            seed       = DW'($urandom);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = (cyc < 7) ? rdy_pat[cyc] : 1'b1;
            endcase
            out_ready = rdy;
            if (amode == 1 && expv && frame == aframe && beat == 1) abort = 1'b1;
            if (amode == 2 && !expv && frame == aframe + 1) abort = 1'b1;
            tick();
            if (expv) begin
                if (rdy) begin
                    if (beat == len) begin
                        frame++;
                        sent++;
                        beat = 0;
                        if ((cnt != 0 && sent == cnt) || abort) begin
                            fin = 1'b1;
                        end else if (gp != 0) begin
                            expv     = 1'b0;
                            gap_left = gp;
                        end
                    end else begin
                        beat++;
                    end
                end
            end else if (abort) begin
                fin = 1'b1;
            end else begin
                gap_left--;
                if (gap_left == 0) expv = 1'b1;
            end
        end
        chk("run_finished", fin, 1'b1);
        chk("end_done", done, 1'b1);
        chk("end_busy", busy, 1'b0);
        chk("end_valid", out_valid, 1'b0);
        chk("end_framesSent", framesSent, 8'(sent));
        abort     = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("done_pulse_end", done, 1'b0);
        chk("idle_valid", out_valid, 1'b0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rdy_pat    = 7'b1001011;
        resetn     = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        frameLen   = '0;
        frameCount = '0;
        gap        = '0;
        seed       = '0;
        repeat (3) tick();

        // reset state
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_framesSent", framesSent, 0);
        resetn = 1'b1;
        tick();
        chk("idle_busy", busy, 1'b0);

        // start together with abort is ignored
        frameLen = 8'd2;
        start    = 1'b1;
        abort    = 1'b1;
        tick();
        tick();
        chk("abort_start_busy", busy, 1'b0);
        chk("abort_start_valid", out_valid, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        tick();

        // directed cases
        do_run(3, 1, 0, 5, 0, 0, 0);     // single frame 5,6,7,0
        do_run(3, 1, 0, 5, 2, 0, 0);     // backpressure pattern
        do_run(1, 2, 2, 0, 0, 0, 0);     // gap of two cycles
        do_run(3, 0, 0, 3, 0, 1, 0);     // continuous, abort on 2nd beat
        do_run(3, 0, 2, 6, 1, 1, 2);     // continuous with gaps, abort in 3rd frame
        do_run(2, 0, 3, 1, 0, 2, 0);     // abort in first gap
        do_run(2, 0, 3, 1, 1, 2, 1);     // abort in second gap
        do_run(0, 3, 0, 2, 0, 0, 0);     // single-beat frames
        do_run(255, 1, 0, int'($urandom_range(0, 7)), 0, 0, 0); // maximum frame length
        do_run(0, 2, 15, 4, 0, 0, 0);    // maximum gap

        // reset in the middle of a frame
        frameLen   = 8'd3;
        frameCount = 8'd1;
        gap        = 4'd0;
        seed       = 3'd5;
        start      = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_last", out_last, 1'b0);
        chk("midrst_data", out_data, 0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_framesSent", framesSent, 0);
        tick();
        chk("midrst_hold_valid", out_valid, 1'b0);
        resetn    = 1'b1;
        out_ready = 1'b0;
        tick();
        do_run(3, 1, 0, 1, 1, 0, 0);     // restarts at new seed 1

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            do_run(int'($urandom_range(0, 9)), int'($urandom_range(1, 4)),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 7)), 1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
